// File: rtl/debounce_pkg.sv
// Shared defaults and channel indices for the push-button debouncer array.
package debounce_pkg;

    localparam int DEF_NUM_CH        = 3;
    localparam int DEF_STABLE_CYCLES = 16;
    localparam int DEF_SYNC_STAGES   = 2;

    localparam int CH_RESET  = 0;
    localparam int CH_WALK   = 1;
    localparam int CH_REPROG = 2;

endpackage : debounce_pkg

// File: rtl/debounce_channel.sv
// Single-bit debouncer: synchroniser, bounce-restart counter, edge pulses and
// a sticky press latch cleared by acknowledge.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic raw_in,
    input  logic ack_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic press_latched
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   press_q, press_d;
    logic                   s_c;

    always_ff @(posedge clk or posedge sys_reset) begin
        if (sys_reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
        end
    end

    // Any sample matching the output restarts the stability count.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
        s_c    = sync_q[SYNC_STAGES-1];
        cnt_d  = '0;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (s_c != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d   = s_c;
                rise_d = s_c;
                fall_d = ~s_c;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        // A press arriving with an acknowledge is kept.
        press_d = rise_q | (press_q & ~ack_in);
    end

    assign db_out        = db_q;
    assign rise_pulse    = rise_q;
    assign fall_pulse    = fall_q;
    assign press_latched = press_q;

endmodule : debounce_channel

// File: rtl/button_debouncer_array.sv
// Array of independent button debouncers sharing one clock and reset.
module button_debouncer_array
    import debounce_pkg::*;
#(
    parameter int NUM_CH        = DEF_NUM_CH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic              clk,
    input  logic              sys_reset,
    input  logic [NUM_CH-1:0] raw_in,
    input  logic [NUM_CH-1:0] ack_in,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] press_latched
);

    if (NUM_CH < 1 || STABLE_CYCLES < 1 || SYNC_STAGES < 2) begin : g_bad_params
        $error("button_debouncer_array: need NUM_CH>=1, STABLE_CYCLES>=1, SYNC_STAGES>=2");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES (STABLE_CYCLES),
            .SYNC_STAGES   (SYNC_STAGES)
        ) u_ch (
            .clk           (clk),
            .sys_reset     (sys_reset),
            .raw_in        (raw_in[i]),
            .ack_in        (ack_in[i]),
            .db_out        (db_out[i]),
            .rise_pulse    (rise_pulse[i]),
            .fall_pulse    (fall_pulse[i]),
            .press_latched (press_latched[i])
        );
    end

endmodule : button_debouncer_array
